// File: rtl/ula_seq.sv
// ula_seq: handshaked sequential ALU.
// Single-cycle logic, shift and compare ops return their result one cycle after acceptance.
// Define ULA_SEQ_MUL_EN to build the iterative shift-add multiplier for op 4.
// When the multiplier is built, a multiply takes WIDTH+1 cycles.
// Without ULA_SEQ_MUL_EN, op 4 is a single-cycle op that returns 0.
// Results are held until the consumer takes them.
// When the consumer takes a result, a new request is accepted on the same edge.
module ula_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

  state_t           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, carry_q, overflow_q, negative_q;
  logic [WIDTH+1:0] alu_d;
  logic             accept;

  // Evaluate one single-cycle operation and return {carry, overflow, result}.
  function automatic logic [WIDTH+1:0] alu_eval(input logic [3:0] f_op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0]        r;
    logic                    c;
    logic                    v;
    logic [WIDTH:0]          s;
    logic [WIDTH-1:0]        t;
    logic [SHW-1:0]          amt;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    s   = '0;
    t   = '0;
    amt = b[SHW-1:0];
    sa  = a;
    sb  = b;
    case (f_op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      4'd3: begin
        r = a >> amt;
        if (amt != '0) begin
          t = a >> (amt - 1'b1);
          c = t[0];
        end
      end
      4'd5: begin
        r = a << amt;
        if (amt != '0) begin
          t = a << (amt - 1'b1);
          c = t[WIDTH-1];
        end
      end
      4'd6: begin
        s = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      4'd7: r[0] = (a < b);
      4'd8: r[0] = (sa < sb);
      4'd9: begin
        r = sa >>> amt;
        if (amt != '0) begin
          t = a >> (amt - 1'b1);
          c = t[0];
        end
      end
      4'd10: r = a ^ b;
      4'd11: r = ~(a | b);
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  // Combinational result of the single-cycle operation on the current request.
  always_comb begin
    alu_d = alu_eval(op, src_a, src_b);
  end

  assign in_ready  = rst_n & ((state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign negative  = negative_q;

`ifdef ULA_SEQ_MUL_EN
  // Shift-add multiplier state: {high accumulator, remaining multiplier bits}.
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   mcand_q;
  logic [SHW-1:0]     cnt_q;
  logic [WIDTH:0]     msum_d;

  // One multiplier step: conditionally add the multiplicand, then shift right.
  always_comb begin
    msum_d = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d = {msum_d, prod_q[WIDTH-1:1]};
  end
`endif

  // Control FSM with registered result, flags and valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      negative_q  <= 1'b0;
`ifdef ULA_SEQ_MUL_EN
      prod_q      <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_HOLD: begin
          if (accept) begin
`ifdef ULA_SEQ_MUL_EN
            if (op == 4'd4) begin
              state_q     <= S_MUL;
              out_valid_q <= 1'b0;
              prod_q      <= {{WIDTH{1'b0}}, src_b};
              mcand_q     <= src_a;
              cnt_q       <= '0;
            end else begin
`endif
              state_q     <= S_HOLD;
              out_valid_q <= 1'b1;
              result_q    <= alu_d[WIDTH-1:0];
              carry_q     <= alu_d[WIDTH+1];
              overflow_q  <= alu_d[WIDTH];
              zero_q      <= (alu_d[WIDTH-1:0] == '0);
              negative_q  <= alu_d[WIDTH-1];
`ifdef ULA_SEQ_MUL_EN
            end
`endif
          end else if ((state_q == S_HOLD) && out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
`ifdef ULA_SEQ_MUL_EN
        S_MUL: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH-1)) begin
            state_q     <= S_HOLD;
            out_valid_q <= 1'b1;
            result_q    <= prod_d[WIDTH-1:0];
            carry_q     <= |prod_d[2*WIDTH-1:WIDTH];
            overflow_q  <= 1'b0;
            zero_q      <= (prod_d[WIDTH-1:0] == '0);
            negative_q  <= prod_d[WIDTH-1];
          end
        end
`endif
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed and randomized checks of ula_seq at WIDTH=8 against an arithmetic model.
// The expectations for op 4 follow ULA_SEQ_MUL_EN, so compile the bench with the same defines as the RTL.
module tb_ula_seq;

  localparam int     W    = 8;
  localparam longint MOD  = longint'(1) << W;
  localparam longint HALF = longint'(1) << (W - 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, carry, overflow, negative;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ula_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .carry(carry),
    .overflow(overflow), .negative(negative)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: operation semantics with plain integer arithmetic; lat = cycles from accept to out_valid.
  function automatic void ref_model(input int o, input longint a, input longint b,
                                    output longint r, output longint c,
                                    output longint v, output longint lat);
    longint sa, sb, t;
    int k;
    sa  = (a >= HALF) ? a - MOD : a;
    sb  = (b >= HALF) ? b - MOD : b;
    k   = int'(b % W);
    r   = 0; c = 0; v = 0; lat = 1;
    case (o)
      0: r = a & b;
      1: r = a | b;
      2: begin t = a + b; r = t % MOD; c = (t >= MOD); t = sa + sb; v = (t < -HALF) || (t >= HALF); end
      3: begin r = a >> k; c = (k != 0) ? ((a >> (k - 1)) & 1) : 0; end
      4: begin
`ifdef ULA_SEQ_MUL_EN
        t = a * b; r = t % MOD; c = (t >= MOD); lat = W + 1;
`endif
      end
      5: begin r = (a << k) % MOD; c = (k != 0) ? ((a >> (W - k)) & 1) : 0; end
      6: begin r = (a - b + MOD) % MOD; c = (a >= b); t = sa - sb; v = (t < -HALF) || (t >= HALF); end
      7: r = (a < b) ? 1 : 0;
      8: r = (sa < sb) ? 1 : 0;
      9: begin t = sa >>> k; r = t & (MOD - 1); c = (k != 0) ? ((a >> (k - 1)) & 1) : 0; end
      10: r = a ^ b;
      11: r = (~(a | b)) & (MOD - 1);
      default: r = 0;
    endcase
  endfunction

  // Issue one op, measure latency, check result/flags, hold for 'hold' cycles, retire.
  // With poke set, in_valid stays high with other operands while the op is in flight.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit poke);
    longint er, ec, ev, el;
    int lat;
    logic [W-1:0] held;
    ref_model(int'(o), longint'(a), longint'(b), er, ec, ev, el);
    @(negedge clk);
    in_valid = 1'b1; op = o; src_a = a; src_b = b; out_ready = 1'b0;
    #1 check("acc_rdy", in_ready, 1);
    @(negedge clk);
    in_valid = poke;
    if (poke) begin op = 4'd2; src_a = W'($urandom); src_b = W'($urandom); end
    lat = 1;
    while (!out_valid && lat <= 2 * W + 4) begin
      if (poke) check("busy_rdy", in_ready, 0);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, el);
    check("result", result, er);
    check("zero", zero, (er == 0) ? 1 : 0);
    check("carry", carry, ec);
    check("overflow", overflow, ev);
    check("negative", negative, (er >> (W - 1)) & 1);
    held = result;
    repeat (hold) begin
      @(negedge clk);
      check("hold_res", result, held);
      check("hold_rdy", in_ready, 0);
      check("hold_vld", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("retire", out_valid, 0);
  endtask

  // Result held 5 cycles, then retire and accept a new op on the same edge.
  task automatic back_to_back();
    longint r1, c1, v1, l1, r2, c2, v2, l2;
    logic [W-1:0] a1, b1, a2, b2;
    a1 = W'($urandom); b1 = W'($urandom); a2 = W'($urandom); b2 = W'($urandom);
    ref_model(2, longint'(a1), longint'(b1), r1, c1, v1, l1);
    ref_model(10, longint'(a2), longint'(b2), r2, c2, v2, l2);
    @(negedge clk);
    in_valid = 1'b1; op = 4'd2; src_a = a1; src_b = b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_v1", out_valid, 1);
    check("b2b_r1", result, r1);
    repeat (5) begin
      @(negedge clk);
      check("b2b_hold", result, r1);
      check("b2b_hrdy", in_ready, 0);
    end
    in_valid = 1'b1; op = 4'd10; src_a = a2; src_b = b2; out_ready = 1'b1;
    #1 check("b2b_rdy", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_v2", out_valid, 1);
    check("b2b_r2", result, r2);
    check("b2b_z2", zero, (r2 == 0) ? 1 : 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_ret", out_valid, 0);
  endtask

  // Reset asserted mid-multiply: nothing is delivered and the block returns idle.
  task automatic reset_abort();
    @(negedge clk);
    in_valid = 1'b1; op = 4'd4; src_a = 8'h0F; src_b = 8'h11; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1 check("rst_rdy", in_ready, 0);
    repeat (2) @(negedge clk);
    check("rst_vld", out_valid, 0);
    check("rst_res", result, 0);
    check("rst_carry", carry, 0);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("rst_novld", out_valid, 0);
    end
    check("rst_idle", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("r_vld", out_valid, 0);
    check("r_res", result, 0);
    check("r_flags", {zero, carry, overflow, negative}, 0);
    check("r_rdy", in_ready, 0);
    rst_n = 1'b1;

    run_op(4'd2, 8'hFF, 8'h01, 0, 1'b0);
    run_op(4'd6, 8'h80, 8'h01, 0, 1'b0);
    run_op(4'd8, 8'h80, 8'h01, 0, 1'b0);
    run_op(4'd7, 8'h80, 8'h01, 0, 1'b0);
    run_op(4'd9, 8'h90, 8'h02, 0, 1'b0);
    run_op(4'd3, 8'h90, 8'h02, 1, 1'b0);
    run_op(4'd5, 8'h81, 8'h01, 0, 1'b0);
    run_op(4'd5, 8'h81, 8'h00, 0, 1'b0);
    run_op(4'd4, 8'h0F, 8'h11, 0, 1'b1);
    run_op(4'd4, 8'h10, 8'h10, 2, 1'b1);
    run_op(4'd4, 8'h03, 8'h05, 0, 1'b0);
    run_op(4'd11, 8'h0F, 8'h30, 5, 1'b0);
    run_op(4'd13, 8'h5A, 8'hA5, 0, 1'b0);
    back_to_back();
    reset_abort();

    for (int i = 0; i < 80; i++) begin
      run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; legal values 8, 16, 32.
REQ-002 SHALL derive localparam SHW = $clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request present.
REQ-006 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port op  input  4  operation select.
REQ-008 SHALL have port src_a  input  WIDTH  operand A.
REQ-009 SHALL have port src_b  input  WIDTH  operand B; shifts use src_b[SHW-1:0] as amount.
REQ-010 SHALL have port out_valid  output  1  result and flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port result  output  WIDTH  registered result.
REQ-013 SHALL have ports zero, carry, overflow, negative  output  1 each  registered flags.

Function
REQ-014 SHALL decode op: 0 AND, 1 OR, 2 ADD, 3 SRL, 4 MUL, 5 SLL, 6 SUB (A+~B+1), 7 SLTU, 8 SLT signed, 9 SRA, 10 XOR, 11 NOR; ops 12-15 give result 0.
REQ-015 SHALL implement FSM IDLE, MUL, HOLD; reset state IDLE.
REQ-016 SHALL drive in_ready = (state==IDLE) | (state==HOLD & out_ready), forced 0 while rst_n low.
REQ-017 SHALL accept a request on in_valid & in_ready, capturing op, src_a, src_b that edge.
REQ-018 SHALL, for non-MUL ops, register result and flags on the accept edge and enter HOLD: out_valid high the cycle after acceptance (latency 1).
REQ-019 SHALL, for MUL, enter MUL and do one shift-add step per cycle for WIDTH cycles, then enter HOLD: out_valid high WIDTH+1 cycles after acceptance.
REQ-020 SHALL set MUL result to product[WIDTH-1:0]; carry = |product[2*WIDTH-1:WIDTH].
REQ-021 SHALL hold result, flags, out_valid stable in HOLD until out_ready sampled high.
REQ-022 SHALL, on out_ready & in_valid in HOLD, retire the current result and accept the new request that edge (back-to-back, no bubble).
REQ-023 SHALL, on out_ready without in_valid in HOLD, return to IDLE and drop out_valid next cycle.
REQ-024 SHALL ignore in_valid while in MUL (in_ready low).
REQ-025 SHALL set zero = (result==0), negative = result[WIDTH-1] for every op.
REQ-026 SHALL set carry: ADD carry-out; SUB carry-out of A+~B+1 (1 when A>=B unsigned); SRL/SRA last bit shifted out, SLL last bit shifted out, 0 when amount 0; MUL per REQ-020; else 0.
REQ-027 SHALL set overflow for ADD/SUB on signed two's-complement overflow; else 0.
REQ-028 SHALL set SLTU/SLT result to 1 or 0 zero-extended to WIDTH.

Reset
REQ-029 SHALL, while rst_n low at a clk edge, force state IDLE, out_valid 0, result 0, all flags 0, MUL accumulator 0.
REQ-030 SHALL abort an in-progress MUL or held result when rst_n asserted; no out_valid follows.
REQ-031 SHALL accept a request no earlier than the first edge with rst_n high.

Configuration
REQ-032 SHALL compile the iterative multiplier only when macro ULA_SEQ_MUL_EN is defined.
REQ-033 SHALL, without ULA_SEQ_MUL_EN, treat op 4 as single-cycle with result 0, zero 1, other flags 0, latency 1; MUL state unreachable.

Verification (WIDTH=8, ULA_SEQ_MUL_EN defined unless stated)
REQ-034 SHALL test ADD 0xFF+0x01 -> result 0x00, zero 1, carry 1, overflow 0, out_valid one cycle after accept.
REQ-035 SHALL test SUB 0x80-0x01 -> 0x7F, overflow 1, carry 1; SLT 0x80 vs 0x01 -> 1; SLTU same -> 0.
REQ-036 SHALL test SRA 0x90 by 2 -> 0xE4, negative 1; SRL 0x90 by 2 -> 0x24; SLL 0x81 by 1 -> 0x02, carry 1.
REQ-037 SHALL test MUL 0x0F*0x11 -> 0xFF, carry 0, out_valid 9 cycles after accept; 0x10*0x10 -> 0x00, zero 1, carry 1; in_valid during MUL ignored.
REQ-038 SHALL test out_ready low 5 cycles in HOLD -> result stable, in_ready 0; then out_ready & in_valid same cycle -> new op accepted, next result valid following cycle.
REQ-039 SHALL test rst_n low 3 cycles into MUL -> out_valid 0, state IDLE; macro undefined: op 4 on 0x03,0x05 -> result 0, zero 1, latency 1.
